// File: rtl/level_trigger.sv
`default_nettype none
// ============================================================================
// Module   : level_trigger
// Purpose  : Multi-lane ADC level trigger with hysteresis, quiet-sample packet
//            end detection and post-packet holdoff. Define
//            LEVEL_TRIGGER_STATS_EN to enable the trig_count packet counter.
// Revision : 1.0 - initial release
// ============================================================================
module level_trigger #(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 2,
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [SAMPLE_W*LANES-1:0] adc_data,
    input  logic                      adc_data_valid,
    input  logic                      enable,
    input  logic                      polarity,
    input  logic [SAMPLE_W-1:0]       threshold,
    input  logic [SAMPLE_W-1:0]       hysteresis,
    input  logic [31:0]               n_sample,
    input  logic [31:0]               holdoff,
    output logic                      sync,
    output logic                      trig_pulse,
    output logic [LANE_W-1:0]         trig_lane,
    output logic [31:0]               trig_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [31:0]         r_quiet;
    logic [31:0]         r_hcnt;
    logic                r_sync;
    logic                r_pulse;
    logic [LANE_W-1:0]   r_lane;
    logic [LANE_W-1:0]   w_first_lane;
    logic [LANES-1:0]    w_hit;
    logic [LANES-1:0]    w_hold;
    logic                w_start;
    logic                w_sync_d;
    logic [SAMPLE_W:0]   w_sum;
    logic [SAMPLE_W:0]   w_diff;
    logic [SAMPLE_W-1:0] w_hold_hi;
    logic [SAMPLE_W-1:0] w_hold_lo;
    logic [32:0]         w_quiet_add;
    logic [31:0]         w_quiet_inc;
    logic                w_quiet_done;
    logic                w_hold_done;

    // Release levels saturate at the sample range instead of wrapping
    assign w_sum     = {1'b0, threshold} + {1'b0, hysteresis};
    assign w_diff    = {1'b0, threshold} - {1'b0, hysteresis};
    assign w_hold_hi = w_sum[SAMPLE_W]  ? '1 : w_sum[SAMPLE_W-1:0];
    assign w_hold_lo = w_diff[SAMPLE_W] ? '0 : w_diff[SAMPLE_W-1:0];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [SAMPLE_W-1:0] w_sample;
        assign w_sample    = adc_data[gi*SAMPLE_W +: SAMPLE_W];
        assign w_hit[gi]   = polarity ? (w_sample > threshold) : (w_sample < threshold);
        assign w_hold[gi]  = polarity ? (w_sample > w_hold_lo) : (w_sample < w_hold_hi);
    end

    always_comb begin
        w_first_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_first_lane = LANE_W'(i);
            end
        end
    end

    assign w_quiet_add  = {1'b0, r_quiet} + 33'(LANES);
    assign w_quiet_inc  = w_quiet_add[32] ? '1 : w_quiet_add[31:0];
    assign w_quiet_done = (r_quiet >= n_sample);
    assign w_hold_done  = (({1'b0, r_hcnt} + 33'd1) >= {1'b0, holdoff});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next = S_ARMED;
                S_ARMED:   if (adc_data_valid && (|w_hit)) w_next = S_ACTIVE;
                S_ACTIVE:  if (w_quiet_done) w_next = (holdoff != 32'd0) ? S_HOLDOFF : S_ARMED;
                S_HOLDOFF: if (w_hold_done) w_next = S_ARMED;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start  = (r_state == S_ARMED) && (w_next == S_ACTIVE);
        w_sync_d = (w_next == S_ACTIVE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_quiet <= '0;
            r_hcnt  <= '0;
            r_sync  <= 1'b0;
            r_pulse <= 1'b0;
            r_lane  <= '0;
        end else begin
            r_sync  <= w_sync_d;
            r_pulse <= w_start;
            if (w_start) begin
                r_lane <= w_first_lane;
            end
            if (w_start) begin
                r_quiet <= '0;
            end else if ((r_state == S_ACTIVE) && adc_data_valid) begin
                r_quiet <= (|w_hold) ? 32'd0 : w_quiet_inc;
            end
            // Counter restarts from zero on every HOLDOFF entry
            if ((r_state == S_HOLDOFF) && (w_next == S_HOLDOFF)) begin
                r_hcnt <= r_hcnt + 32'd1;
            end else begin
                r_hcnt <= '0;
            end
        end
    end

    assign sync       = r_sync;
    assign trig_pulse = r_pulse;
    assign trig_lane  = r_lane;

`ifdef LEVEL_TRIGGER_STATS_EN
    logic [31:0] r_count;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= r_count + 32'd1;
        end
    end
    assign trig_count = r_count;
`else
    assign trig_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_level_trigger.sv
`default_nettype none
// Testbench for level_trigger: randomized and directed stimulus checked by a
// queue-based scoreboard against a behavioural packet model.
module tb_level_trigger;
    localparam int SW = 16;
    localparam int LN = 2;
    localparam int LW = 1;
`ifdef LEVEL_TRIGGER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk            = 1'b0;
    logic              resetn         = 1'b0;
    logic [SW*LN-1:0]  adc_data       = '0;
    logic              adc_data_valid = 1'b0;
    logic              enable         = 1'b0;
    logic              polarity       = 1'b0;
    logic [SW-1:0]     threshold      = '0;
    logic [SW-1:0]     hysteresis     = '0;
    logic [31:0]       n_sample       = '0;
    logic [31:0]       holdoff        = '0;
    logic              sync;
    logic              trig_pulse;
    logic [LW-1:0]     trig_lane;
    logic [31:0]       trig_count;

    always #5 clk = ~clk;

    level_trigger #(.SAMPLE_W(SW), .LANES(LN)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .enable         (enable),
        .polarity       (polarity),
        .threshold      (threshold),
        .hysteresis     (hysteresis),
        .n_sample       (n_sample),
        .holdoff        (holdoff),
        .sync           (sync),
        .trig_pulse     (trig_pulse),
        .trig_lane      (trig_lane),
        .trig_count     (trig_count)
    );

    typedef struct packed {
        logic        sync;
        logic        pulse;
        logic [31:0] cnt;
    } exp_t;

    typedef enum {M_IDLE, M_ARMED, M_ACTIVE, M_HOLDOFF} mode_e;

    exp_t        exp_q[$];
    int          lane_q[$];
    int          checks = 0;
    int          errors = 0;

    mode_e       m_mode  = M_IDLE;
    longint      m_quiet = 0;
    longint      m_hcyc  = 0;
    logic [31:0] m_count = '0;

    // Predicts the outputs seen after the next rising edge from current inputs
    task automatic model_step();
        exp_t   e;
        bit     pulse    = 1'b0;
        bit     any_hold = 1'b0;
        int     first    = -1;
        longint thr, hy, hi, lo, s;
        mode_e  nxt;
        thr = longint'(threshold);
        hy  = longint'(hysteresis);
        hi  = thr + hy;
        if (hi > 65535) hi = 65535;
        lo  = thr - hy;
        if (lo < 0) lo = 0;
        for (int i = 0; i < LN; i++) begin
            s = longint'(adc_data[i*SW +: SW]);
            if (first < 0 && (polarity ? (s > thr) : (s < thr))) first = i;
            if (polarity ? (s > lo) : (s < hi)) any_hold = 1'b1;
        end
        if (!resetn) begin
            m_mode  = M_IDLE;
            m_quiet = 0;
            m_hcyc  = 0;
            m_count = '0;
        end else begin
            nxt = m_mode;
            if (!enable) begin
                nxt = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: nxt = M_ARMED;
                    M_ARMED: begin
                        if (adc_data_valid && first >= 0) begin
                            nxt     = M_ACTIVE;
                            pulse   = 1'b1;
                            m_quiet = 0;
                            m_count = m_count + 32'd1;
                            lane_q.push_back(first);
                        end
                    end
                    M_ACTIVE: begin
                        if (m_quiet >= longint'(n_sample)) begin
                            nxt    = (holdoff == 32'd0) ? M_ARMED : M_HOLDOFF;
                            m_hcyc = 0;
                        end
                        if (adc_data_valid) begin
                            if (any_hold) m_quiet = 0;
                            else if (m_quiet + LN > 64'hFFFF_FFFF) m_quiet = 64'hFFFF_FFFF;
                            else m_quiet = m_quiet + LN;
                        end
                    end
                    M_HOLDOFF: begin
                        m_hcyc = m_hcyc + 1;
                        if (m_hcyc >= longint'(holdoff)) nxt = M_ARMED;
                    end
                    default: nxt = M_IDLE;
                endcase
            end
            m_mode = nxt;
        end
        e.sync  = (m_mode == M_ACTIVE);
        e.pulse = pulse;
        e.cnt   = STATS ? m_count : 32'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: checks every presented cycle, and the lane on every trigger
    always @(posedge clk) begin : monitor
        exp_t e;
        int   l;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (sync !== e.sync || trig_pulse !== e.pulse || trig_count !== e.cnt) begin
                errors++;
                $display("FAIL outputs @%0t: got sync=%b pulse=%b count=%0d, expected sync=%b pulse=%b count=%0d",
                         $time, sync, trig_pulse, trig_count, e.sync, e.pulse, e.cnt);
            end
        end
        if (trig_pulse === 1'b1) begin
            checks++;
            if (lane_q.size() == 0) begin
                errors++;
                $display("FAIL trig_lane @%0t: got trigger on lane %0d, expected no trigger", $time, trig_lane);
            end else begin
                l = lane_q.pop_front();
                if (trig_lane !== LW'(l)) begin
                    errors++;
                    $display("FAIL trig_lane @%0t: got %0d, expected %0d", $time, trig_lane, l);
                end
            end
        end
    end

    // Apply one input word at the current falling edge, then advance a cycle
    task automatic cyc(input bit v, input logic [SW-1:0] l1, input logic [SW-1:0] l0);
        adc_data       = {l1, l0};
        adc_data_valid = v;
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        resetn         = 1'b0;
        adc_data_valid = 1'b0;
        #1;
        checks++;
        if (sync !== 1'b0 || trig_pulse !== 1'b0 || trig_lane !== '0 || trig_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset @%0t: got sync=%b pulse=%b lane=%0d count=%0d, expected all 0",
                     $time, sync, trig_pulse, trig_lane, trig_count);
        end
        model_step();
        @(negedge clk);
        repeat (n - 1) cyc(1'b0, '0, '0);
        resetn = 1'b1;
    endtask

    function automatic logic [SW-1:0] rnd_sample();
        int v;
        if ($urandom_range(0, 1) == 0) return SW'($urandom);
        v = int'(threshold) + int'($urandom_range(0, 2048)) - 1024;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return SW'(v);
    endfunction

    initial begin
        repeat (3) cyc(1'b0, '0, '0);
        resetn = 1'b1;

        // Below-threshold trigger, hysteresis hold, quiet end, holdoff
        polarity = 1'b0; threshold = 16'h1000; hysteresis = 16'h0100;
        n_sample = 32'd6; holdoff = 32'd4; enable = 1'b1;
        repeat (2) cyc(1'b0, '0, '0);
        cyc(1'b1, 16'h2000, 16'h0800);
        repeat (3) cyc(1'b1, 16'h1080, 16'h1080);
        repeat (3) cyc(1'b1, 16'h1200, 16'h1200);
        repeat (8) cyc(1'b1, 16'h0100, 16'h0100);
        repeat (4) cyc(1'b1, 16'h1200, 16'h1200);
        repeat (6) cyc(1'b0, '0, '0);

        // Above-threshold trigger near the top of the range, lane 1 hit
        polarity = 1'b1; threshold = 16'hFFF0; hysteresis = 16'h0020;
        cyc(1'b1, 16'hFFF8, 16'h0000);
        repeat (3) cyc(1'b1, 16'hFFD5, 16'h0000);
        repeat (4) cyc(1'b1, 16'h0000, 16'h0000);
        repeat (6) cyc(1'b0, '0, '0);

        // Abort by enable drop, then by reset
        cyc(1'b1, 16'hFFFF, 16'hFFFF);
        cyc(1'b1, 16'hFFFF, 16'hFFFF);
        enable = 1'b0;
        cyc(1'b0, '0, '0);
        enable = 1'b1;
        repeat (2) cyc(1'b0, '0, '0);
        cyc(1'b1, 16'hFFFF, 16'h0000);
        cyc(1'b1, 16'hFFFF, 16'hFFFF);
        do_reset(2);

        // Single-cycle packets with no holdoff; saturated release level
        polarity = 1'b0; threshold = 16'hFFF0; hysteresis = 16'h0020;
        n_sample = 32'd0; holdoff = 32'd0;
        repeat (2) cyc(1'b0, '0, '0);
        repeat (5) cyc(1'b1, 16'h0500, 16'hFFFF);

        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                polarity   = 1'($urandom_range(0, 1));
                threshold  = SW'($urandom);
                hysteresis = SW'($urandom_range(0, 1024));
                n_sample   = $urandom_range(0, 12);
                holdoff    = $urandom_range(0, 6);
            end
            enable = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 999) == 0) do_reset(2);
            else cyc($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample());
        end

        enable = 1'b0;
        repeat (3) cyc(1'b0, '0, '0);
        #2;
        checks++;
        if (exp_q.size() != 0 || lane_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outputs and %0d triggers outstanding, expected 0 and 0",
                     exp_q.size(), lane_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
